// File: rtl/prioritized_pkg.sv
// Shared constants and helpers for the prioritized input stage and its word selector.
package prioritized_pkg;

  localparam int DATA_WIDTH_DEFAULT = 8;
  localparam int NUM_INPUTS_DEFAULT = 4;
  localparam int AGE_LIMIT_DEFAULT  = 15;

  // A single-input stage still carries a one-bit index.
  function automatic int index_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prioritized_demux.sv
// One-hot word selector: returns the word whose select bit is set, zero when none is.
module prioritized_demux
  import prioritized_pkg::*;
#(
  parameter int data_width       = DATA_WIDTH_DEFAULT,
  parameter int number_of_inputs = NUM_INPUTS_DEFAULT
) (
  input  logic [data_width-1:0]       in_data [number_of_inputs],
  input  logic [number_of_inputs-1:0] sel,
  output logic [data_width-1:0]       out_data
);

  always_comb begin
    out_data = '0;
    for (int i = 0; i < number_of_inputs; i++) begin
      if (sel[i]) out_data = out_data | in_data[i];
    end
  end

endmodule

// File: rtl/prioritized_input_stage.sv
// Per-input one-entry slots feeding a fixed-priority, registered output (index 0 wins).
// Define PRIORITIZED_AGING_EN to promote slots that have waited age_limit cycles.
//
// Handshakes: a transfer happens on a rising edge where valid && ready; ready never
// depends on valid, and a valid output word stays stable until ready accepts it.
module prioritized_input_stage
  import prioritized_pkg::*;
#(
  parameter int data_width       = DATA_WIDTH_DEFAULT,
  parameter int number_of_inputs = NUM_INPUTS_DEFAULT,
  parameter int age_limit        = AGE_LIMIT_DEFAULT
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [data_width-1:0]                       in_data [number_of_inputs],
  input  logic [number_of_inputs-1:0]                 in_valid,
  output logic [number_of_inputs-1:0]                 in_ready,
  output logic [data_width-1:0]                       out_data,
  output logic [index_width(number_of_inputs)-1:0]    out_index,
  output logic                                        out_valid,
  input  logic                                        out_ready
);

  localparam int N  = number_of_inputs;
  localparam int IW = index_width(number_of_inputs);

  logic [N-1:0]            full_q, full_d;
  logic [data_width-1:0]   word_q [N];
  logic [data_width-1:0]   word_d [N];
  logic [data_width-1:0]   out_data_q, out_data_d;
  logic [IW-1:0]           out_index_q, out_index_d;
  logic                    out_valid_q, out_valid_d;
  logic [N-1:0]            candidates, grant, transfer;
  logic [data_width-1:0]   sel_word;
  logic                    load;

  function automatic logic [N-1:0] pick_lowest(input logic [N-1:0] req);
    logic [N-1:0] onehot;
    onehot = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
      end
    end
    return onehot;
  endfunction

  function automatic logic [IW-1:0] encode(input logic [N-1:0] onehot);
    logic [IW-1:0] idx;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (onehot[i]) idx = IW'(i);
    end
    return idx;
  endfunction

`ifdef PRIORITIZED_AGING_EN
  localparam int            AW      = $clog2(age_limit + 1);
  localparam logic [AW-1:0] AGE_MAX = AW'(age_limit);

  logic [AW-1:0] age_q [N];
  logic [AW-1:0] age_d [N];
  logic [N-1:0]  aged;

  // Aged slots form their own priority tier above the plain full slots.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      aged[i]  = full_q[i] && (age_q[i] == AGE_MAX);
      age_d[i] = (!full_q[i] || grant[i]) ? '0 :
                 (aged[i] ? age_q[i] : age_q[i] + AW'(1));
    end
    candidates = (|aged) ? aged : full_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) age_q[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) age_q[i] <= age_d[i];
    end
  end
`else
  always_comb candidates = full_q;
`endif

  // Ready reaches back to out_ready through grant so a slot can drain and refill each cycle.
  always_comb begin
    load     = !out_valid_q || out_ready;
    grant    = load ? pick_lowest(candidates) : '0;
    in_ready = ~full_q | grant;
  end

  prioritized_demux #(
    .data_width      (data_width),
    .number_of_inputs(N)
  ) u_demux (
    .in_data (word_q),
    .sel     (grant),
    .out_data(sel_word)
  );

  always_comb begin
    for (int i = 0; i < N; i++) begin
      transfer[i] = in_valid[i] && in_ready[i];
      full_d[i]   = (full_q[i] && !grant[i]) || transfer[i];
      word_d[i]   = transfer[i] ? in_data[i] : word_q[i];
    end
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    out_valid_d = out_valid_q;
    if (load) begin
      out_valid_d = |grant;
      if (|grant) begin
        out_data_d  = sel_word;
        out_index_d = encode(grant);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q      <= '0;
      out_data_q  <= '0;
      out_index_q <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < N; i++) word_q[i] <= '0;
    end else begin
      full_q      <= full_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      out_valid_q <= out_valid_d;
      for (int i = 0; i < N; i++) word_q[i] <= word_d[i];
    end
  end

  assign out_data  = out_data_q;
  assign out_index = out_index_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_prioritized_input_stage.sv
// Bench for prioritized_input_stage: directed scenarios plus random traffic against a slot-level model.
module tb_prioritized_input_stage;
  import prioritized_pkg::*;

  localparam int DW = 8;
  localparam int NI = 4;
  localparam int AL = 3;
  localparam int IW = index_width(NI);

  logic              clk = 1'b0;
  logic              rst;
  logic [DW-1:0]     in_data [NI];
  logic [NI-1:0]     in_valid;
  logic [NI-1:0]     in_ready;
  logic [DW-1:0]     out_data;
  logic [IW-1:0]     out_index;
  logic              out_valid;
  logic              out_ready;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  prioritized_input_stage #(
    .data_width      (DW),
    .number_of_inputs(NI),
    .age_limit       (AL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_index(out_index),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit                 started = 1'b0;
  bit                 m_full [NI];
  logic [DW-1:0]      m_word [NI];
  int                 m_wait [NI];
  bit                 m_ov;
  logic [DW-1:0]      m_od;
  int                 m_oi;
  logic [IW+DW-1:0]   exp_q[$];
  bit                 fire_s;
  logic [DW-1:0]      s_data;
  logic [IW-1:0]      s_idx;

  // Which slot the stage must hand out this cycle, -1 for none.
  function automatic int winner(input bit free);
    if (!free) return -1;
`ifdef PRIORITIZED_AGING_EN
    for (int i = 0; i < NI; i++) if (m_full[i] && m_wait[i] >= AL) return i;
`endif
    for (int i = 0; i < NI; i++) if (m_full[i]) return i;
    return -1;
  endfunction

  initial begin
    fire_s = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (started) begin
        int w;
        logic [NI-1:0] er;
        w = winner(!m_ov || out_ready);
        for (int i = 0; i < NI; i++) er[i] = !m_full[i] || (w == i);
        check("in_ready", in_ready, er);
        check("out_valid", out_valid, m_ov);
        check("out_data", out_data, m_od);
        check("out_index", out_index, m_oi);
        fire_s = out_valid && out_ready;
        s_data = out_data;
        s_idx  = out_index;
      end
      @(posedge clk);
      if (rst) begin
        for (int i = 0; i < NI; i++) begin
          m_full[i] = 1'b0;
          m_word[i] = '0;
          m_wait[i] = 0;
        end
        m_ov = 1'b0;
        m_od = '0;
        m_oi = 0;
        exp_q.delete();
      end else begin
        int  w;
        bit  ld, g, acc;
        if (started && fire_s) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard actual=%0h required=none at %0t", {s_idx, s_data}, $time);
          end else begin
            check("scoreboard", {s_idx, s_data}, exp_q.pop_front());
          end
        end
        ld = !m_ov || out_ready;
        w  = winner(ld);
        if (ld) begin
          if (w >= 0) begin
            m_od = m_word[w];
            m_oi = w;
            m_ov = 1'b1;
            exp_q.push_back({IW'(w), m_word[w]});
          end else begin
            m_ov = 1'b0;
          end
        end
        for (int i = 0; i < NI; i++) begin
          g   = (w == i);
          acc = in_valid[i] && (!m_full[i] || g);
          if (!m_full[i] || g) m_wait[i] = 0;
          else if (m_wait[i] < AL) m_wait[i]++;
          m_full[i] = (m_full[i] && !g) || acc;
          if (acc) m_word[i] = in_data[i];
        end
      end
      started = 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic expect_out(input string name, input logic v, input logic [DW-1:0] d,
                            input logic [IW-1:0] idx);
    check({name, "_valid"}, out_valid, v);
    if (v) begin
      check({name, "_data"}, out_data, d);
      check({name, "_index"}, out_index, idx);
    end
  endtask

  initial begin
    int seen_edge;
    rst       = 1'b1;
    in_valid  = '1;
    out_ready = 1'b1;
    for (int i = 0; i < NI; i++) in_data[i] = DW'($urandom);

    // Reset with all producers valid: nothing may be captured.
    repeat (2) step();
    rst      = 1'b0;
    in_valid = '0;
    #3;
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data", out_data, 0);
    check("reset_out_index", out_index, 0);
    check("reset_in_ready", in_ready, 4'hf);
    repeat (3) begin
      step();
      #3 check("reset_no_capture", out_valid, 0);
    end

    // Priority: four slots loaded at once drain lowest index first.
    step();
    in_valid = 4'hf;
    for (int i = 0; i < NI; i++) in_data[i] = DW'(8'hA0 + i);
    step();
    in_valid = '0;
    #3 check("prio_latency", out_valid, 0);
    for (int j = 0; j < NI; j++) begin
      step();
      #3 expect_out("prio", 1'b1, DW'(8'hA0 + j), IW'(j));
    end
    step();
    #3 check("prio_drained", out_valid, 0);

    // Backpressure: held word stays put, second word parks in the slot.
    step();
    out_ready   = 1'b0;
    in_valid    = 4'b0100;
    in_data[2]  = 8'h55;
    step();
    in_data[2]  = 8'h66;
    #3 check("bp_refill_ready", in_ready[2], 1);
    step();
    in_valid = '0;
    #3;
    expect_out("bp_hold", 1'b1, 8'h55, 2);
    check("bp_slot_blocked", in_ready[2], 0);
    repeat (4) begin
      step();
      #3;
      expect_out("bp_hold", 1'b1, 8'h55, 2);
      check("bp_slot_blocked", in_ready[2], 0);
    end
    step();
    out_ready = 1'b1;
    #3 check("bp_release_ready", in_ready[2], 1);
    step();
    #3 expect_out("bp_second", 1'b1, 8'h66, 2);
    step();
    #3 check("bp_drained", out_valid, 0);

    // Same-cycle refill: no bubble between the two words of slot 1.
    step();
    in_valid   = 4'b0010;
    in_data[1] = 8'h11;
    step();
    in_data[1] = 8'h22;
    #3 check("refill_ready", in_ready[1], 1);
    step();
    in_valid = '0;
    #3 expect_out("refill_first", 1'b1, 8'h11, 1);
    step();
    #3 expect_out("refill_second", 1'b1, 8'h22, 1);
    step();
    #3 check("refill_drained", out_valid, 0);

    // Aging: slot 0 kept busy while slot 3 waits.
    step();
    in_valid   = 4'b1001;
    in_data[0] = DW'($urandom);
    in_data[3] = 8'h33;
    seen_edge  = -1;
    for (int c = 1; c <= 8; c++) begin
      step();
      in_valid   = 4'b0001;
      in_data[0] = DW'($urandom);
      #3;
      if (seen_edge < 0 && out_valid && out_index == 3) begin
        seen_edge = c - 1;
        check("aging_word", out_data, 8'h33);
      end
    end
`ifdef PRIORITIZED_AGING_EN
    check("aging_bound", (seen_edge >= 1 && seen_edge <= 4), 1);
`else
    check("no_aging_starved", (seen_edge < 0), 1);
`endif
    step();
    in_valid = '0;
    repeat (4) step();

    // Mid-operation reset with every slot full and the output held.
    step();
    out_ready = 1'b0;
    in_valid  = 4'hf;
    for (int i = 0; i < NI; i++) in_data[i] = DW'(8'hB0 + i);
    step();
    for (int i = 0; i < NI; i++) in_data[i] = DW'(8'hC0 + i);
    step();
    in_valid = '0;
    #3 expect_out("mid_before", 1'b1, 8'hB0, 0);
    step();
    rst = 1'b1;
    step();
    rst       = 1'b0;
    out_ready = 1'b1;
    #3 check("mid_reset_valid", out_valid, 0);
    repeat (6) begin
      step();
      #3 check("mid_no_old_word", out_valid, 0);
    end

    // Random traffic against the model.
    repeat (2000) begin
      step();
      rst       = ($urandom_range(0, 199) == 0);
      in_valid  = NI'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NI; i++) in_data[i] = DW'($urandom);
    end
    step();
    rst      = 1'b0;
    in_valid = '0;
    out_ready = 1'b1;
    repeat (8) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
